uart_rx_deserializer: RTL
=========================

// Module: uart_rx_deserializer
// PURPOSE
// - Receive side of the UART link, the counterpart of the TX serializer path.
// - Oversamples the asynchronous RX_IN line and detects the start bit.
// - Majority-votes each bit, shifts DATA_WIDTH bits in LSB-first, then checks optional parity and the stop bit.
// - Presents a parallel byte with a one-cycle valid pulse to the downstream consumer.
// PARAMETERS
// - DATA_WIDTH  8  payload bits per frame.
// - PRESCALE    8  clk cycles per bit (oversample ratio); legal values 8, 16, 32.
// PORTS
// - clk         in   1           single clock; all state on posedge clk.
// - rst         in   1           asynchronous, active-low reset.
// - RX_IN       in   1           serial line; idles high; asynchronous to clk.
// - PAR_EN      in   1           1 = frame carries a parity bit.
// - PAR_TYP     in   1           0 = even, 1 = odd.
// - P_DATA      out  DATA_WIDTH  last received payload.
// - data_valid  out  1           1-cycle pulse: P_DATA updated, frame good.
// - par_err     out  1           1-cycle pulse: parity mismatch.
// - stp_err     out  1           1-cycle pulse: stop bit sampled 0.
// BEHAVIOUR
// - Reset: outputs 0; FSM in IDLE; counters 0; synchronizer flops set to 1 (idle line).
// - Input path: RX_IN passes through a 2-flop synchronizer (rx_s, 2 cycles of latency); all logic uses rx_s only.
// - Per-bit timing: edge_cnt runs 0..PRESCALE-1 and wraps to 0; bit_cnt advances on the wrap.
// - Sampling: rx_s is sampled at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
//   The bit value is the 2-of-3 majority, valid from edge_cnt = PRESCALE/2+2.
// - FSM states: IDLE, START, DATA, PARITY, STOP.
// - IDLE: when rx_s == 0, go to START with edge_cnt = 0.
//   PAR_EN and PAR_TYP are latched in the same cycle; changes during a frame are ignored.
// - START: if the voted bit == 1, treat it as a glitch: return to IDLE at the wrap, no pulses.
//   Otherwise go to DATA.
// - DATA: shift the voted bit into shift_reg[DATA_WIDTH-1], shifting right (LSB first).
//   After DATA_WIDTH bits, go to PARITY if latched PAR_EN = 1, else to STOP.
// - PARITY: expected bit = (^shift_reg) ^ PAR_TYP. A mismatch sets the internal flag perr. Then go to STOP.
// - STOP: on the wrap of the stop bit, return to IDLE.
//   - Voted bit == 0: stp_err = 1 next cycle.
//   - perr set: par_err = 1 next cycle.
//   - Neither error: P_DATA <= shift_reg and data_valid = 1 next cycle.
// - Error frames: P_DATA is not updated; the previous value is held. par_err and stp_err may pulse together.
// - Latency: with T0 = the IDLE cycle that sees rx_s == 0, data_valid is high in cycle T0 + N*PRESCALE.
//   N = 1 + DATA_WIDTH + PAR_EN + 1. Pulses last exactly 1 cycle.
// - Back-to-back frames: the FSM is in IDLE in the pulse cycle, so a new start bit that follows
//   immediately is detected with no lost cycles.
// - Break (line held low): STOP sees 0, so stp_err pulses. IDLE then sees 0 and starts a new frame.
//   A continuous break therefore repeats stp_err once per frame time; this is accepted.
// - Reset mid-frame: everything aborts to the reset state; no pulses.
// STRUCTURE
// - Package uart_pkg holds:
//   - rx_state_t enum (IDLE/START/DATA/PARITY/STOP, 3-bit encoding);
//   - PRESCALE legality constants;
//   - the PAR_EVEN/PAR_ODD constants shared with TX.
// - Sub-module uart_rx_sampler: owns edge_cnt, the 3-tap sample flops and the majority vote.
//   - Outputs: bit_val, bit_tick (at the vote point) and bit_end (at the wrap).
//   - The top level holds the synchronizer, FSM, bit_cnt, shift_reg and error and valid logic.
// TESTING
// - Reset and idle: hold RX_IN = 1 for 200 cycles -> all outputs 0; FSM stays IDLE.
// - 8N1 frame 0xA5, PRESCALE = 8, PAR_EN = 0 -> data_valid pulses once at T0+80, P_DATA = 0xA5, no errors.
// - Even parity on 0x3C: correct parity bit 0 -> valid, P_DATA = 0x3C.
//   Same frame with the parity bit forced to 1 -> par_err pulse only; P_DATA keeps its old value.
// - Stop bit driven 0 on 0x55 -> stp_err pulse at T0+80; no data_valid.
//   A following good 0x0F frame, sent back to back -> valid with P_DATA = 0x0F.
// - Start glitch: RX_IN low for 2 cycles -> no pulses; FSM back in IDLE within PRESCALE+3 cycles.
//   Also drop rst low mid-DATA -> no pulses, and the next frame is received correctly.
// - Jitter: 0x81 sent with single-cycle 1-tap flips at each sample window and a +/-1 cycle bit-edge skew
//   -> 0x81 received intact. Repeat with PRESCALE = 16.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: RX FSM encoding, prescale limits and the parity-type codes
// also used by the TX serializer.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } rx_state_t;

  localparam int unsigned PrescaleMin = 8;
  localparam int unsigned PrescaleMax = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Oversample ratio must be a power of two in [PrescaleMin, PrescaleMax].
  function automatic bit prescale_legal(int unsigned ps);
    return (ps >= PrescaleMin) && (ps <= PrescaleMax) && ((ps & (ps - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing for the RX path: edge counter, three mid-bit sample taps and a
// 2-of-3 majority vote of the synchronized line.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned PRESCALE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_s,
  input  logic run,
  output logic bit_val,
  output logic bit_tick,
  output logic bit_end
);

  localparam int unsigned CntW = $clog2(PRESCALE);
  localparam logic [CntW-1:0] LastEdge = CntW'(PRESCALE - 1);
  localparam logic [CntW-1:0] Tap0     = CntW'(PRESCALE / 2 - 1);
  localparam logic [CntW-1:0] Tap1     = CntW'(PRESCALE / 2);
  localparam logic [CntW-1:0] Tap2     = CntW'(PRESCALE / 2 + 1);
  localparam logic [CntW-1:0] VoteEdge = CntW'(PRESCALE / 2 + 2);

  if (!prescale_legal(PRESCALE)) begin : g_bad_prescale
    $error("uart_rx_sampler: PRESCALE must be 8, 16 or 32");
  end

  logic [CntW-1:0] edge_cnt_q, edge_cnt_d;
  logic [2:0]      taps_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_q <= '0;
      taps_q     <= 3'b111;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      if (run && edge_cnt_q == Tap0) taps_q[0] <= rx_s;
      if (run && edge_cnt_q == Tap1) taps_q[1] <= rx_s;
      if (run && edge_cnt_q == Tap2) taps_q[2] <= rx_s;
    end
  end

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (!run || edge_cnt_q == LastEdge) begin
      edge_cnt_d = '0;
    end else begin
      edge_cnt_d = edge_cnt_q + 1'b1;
    end
  end

  // Taps are registered, so the vote is stable from VoteEdge through the wrap.
  assign bit_val  = (taps_q[0] & taps_q[1]) | (taps_q[0] & taps_q[2]) | (taps_q[1] & taps_q[2]);
  assign bit_tick = run && (edge_cnt_q == VoteEdge);
  assign bit_end  = run && (edge_cnt_q == LastEdge);

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: synchronizes RX_IN, frames start/data/parity/stop bits and
// reports each frame as a valid word or as parity/stop error pulses.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int unsigned BitCntW = $clog2(DATA_WIDTH + 1);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

  rx_state_t             state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  perr_q, perr_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  valid_q, valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  run, bit_val, bit_tick, bit_end;

  // Synchronizer resets to the idle-high line level so reset release never looks like a start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX_IN;
      rx_s_q    <= rx_meta_q;
    end
  end

  // The start-detect cycle counts as edge 0 of the start bit.
  assign run = (state_q != StIdle) || !rx_s_q;

  uart_rx_sampler #(
    .PRESCALE(PRESCALE)
  ) u_sampler (
    .clk     (clk),
    .rst     (rst),
    .rx_s    (rx_s_q),
    .run     (run),
    .bit_val (bit_val),
    .bit_tick(bit_tick),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      p_data_q  <= '0;
      perr_q    <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      p_data_q  <= p_data_d;
      perr_q    <= perr_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    p_data_d  = p_data_q;
    perr_d    = perr_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    valid_d   = 1'b0;
    par_err_d = 1'b0;
    stp_err_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d   = StStart;
          bit_cnt_d = '0;
          perr_d    = 1'b0;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
        end
      end
      StStart: begin
        if (bit_end) state_d = bit_val ? StIdle : StData;
      end
      StData: begin
        if (bit_tick) shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_tick) perr_d = bit_val != ((^shift_q) ^ (par_typ_q == PAR_ODD));
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) begin
          state_d   = StIdle;
          stp_err_d = !bit_val;
          par_err_d = perr_q;
          if (bit_val && !perr_q) begin
            valid_d  = 1'b1;
            p_data_d = shift_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign P_DATA     = p_data_q;
  assign data_valid = valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule
